gauss_spike_encoder: RTL and testbench

- Downstream consumer of the Gaussian output buffer.
- After a frame is filtered, reads every stored pixel once per timestep and converts intensity into a rate-coded spike bit by comparing it against an LFSR pseudo-random value.
- Packs spikes into fixed-width words and streams them to the SNN core over a valid/ready handshake, for NUM_STEPS timesteps per frame.

---
 rtl/gauss_spike_encoder_pkg.sv | 34 +++
 rtl/gauss_spike_encoder_lfsr16.sv | 35 +++
 rtl/gauss_spike_encoder.sv | 181 ++++++++++++++++++
 tb/tb_gauss_spike_encoder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_spike_encoder_pkg.sv
// Shared definitions for the Gaussian spike encoder and the stochastic
// encoders built around the same LFSR.
//   - enc_state_t        : encoder FSM state encoding
//   - LFSR_TAPS          : feedback mask for taps 16,14,13,11 (bits 15,13,12,10)
//   - DEFAULT_LFSR_SEED  : non-zero power-on / start-of-frame LFSR value
//   - words_per_step()   : ceil(pixels / word width)
//   - WORDS_PER_STEP     : word count per timestep for a 28x28 frame, 32-bit words
//   - lfsr_next()        : one Fibonacci step of the 16-bit LFSR
package gauss_spike_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_READ = 3'd1,
    ST_WAIT = 3'd2,
    ST_PACK = 3'd3,
    ST_EMIT = 3'd4,
    ST_DONE = 3'd5
  } enc_state_t;

  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] DEFAULT_LFSR_SEED = 16'hACE1;

  function automatic int words_per_step(input int pixels, input int width);
    return (pixels + width - 1) / width;
  endfunction

  localparam int WORDS_PER_STEP = words_per_step(784, 32);

  // Shift left, XOR of the tapped bits enters at bit 0.
  function automatic logic [15:0] lfsr_next(input logic [15:0] value);
    return {value[14:0], ^(value & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/gauss_spike_encoder_lfsr16.sv
// 16-bit maximal-length Fibonacci LFSR (taps 16,14,13,11).
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset, loads RESET_VALUE
//   load    in   load seed (wins over advance)
//   seed    in   16-bit value to load; must be non-zero
//   advance in   step the register once
//   value   out  current LFSR contents
module lfsr16
  import gauss_spike_encoder_pkg::*;
#(
  parameter logic [15:0] RESET_VALUE = DEFAULT_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        advance,
  output logic [15:0] value
);

  // LFSR state register: reset, reload or single step.
  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RESET_VALUE;
    end else if (load) begin
      value <= seed;
    end else if (advance) begin
      value <= lfsr_next(value);
    end else begin
      value <= value;
    end
  end

endmodule

// File: rtl/gauss_spike_encoder.sv
// Rate-codes a filtered frame into spike words for the SNN core.
// For each of NUM_STEPS timesteps every buffered pixel is read once,
// compared against the LFSR low byte (spike = pixel > lfsr) and packed
// LSB-first into SPIKE_WIDTH-bit words streamed over valid/ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               one-cycle pulse, accepted only when idle
//   busy, done          frame in progress / one-cycle completion pulse
//   rd_en, rd_addr      buffer read request; rd_data valid one cycle later
//   rd_data             pixel intensity from the buffer
//   spike_word          packed spikes, pixel p at bit p mod SPIKE_WIDTH
//   spike_valid/ready   output handshake
//   spike_step          timestep of the current word
//   spike_last          final word of the final timestep
module gauss_spike_encoder
  import gauss_spike_encoder_pkg::*;
#(
  parameter int          IMG_PIXELS  = 784,
  parameter int          DATA_WIDTH  = 8,
  parameter int          ADDR_WIDTH  = 10,
  parameter int          NUM_STEPS   = 16,
  parameter int          SPIKE_WIDTH = 32,
  parameter logic [15:0] LFSR_SEED   = DEFAULT_LFSR_SEED,
  localparam int         STEP_W      = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1,
  localparam int         BIT_W       = $clog2(SPIKE_WIDTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   rd_en,
  output logic [ADDR_WIDTH-1:0]  rd_addr,
  input  logic [DATA_WIDTH-1:0]  rd_data,
  output logic [SPIKE_WIDTH-1:0] spike_word,
  output logic                   spike_valid,
  input  logic                   spike_ready,
  output logic [STEP_W-1:0]      spike_step,
  output logic                   spike_last
);

  enc_state_t             state;
  logic [ADDR_WIDTH-1:0]  pix_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [STEP_W-1:0]      step_cnt;
  logic [DATA_WIDTH-1:0]  pixel_reg;
  logic [SPIKE_WIDTH-1:0] shift_word;

  logic [15:0]            lfsr_value;
  logic                   lfsr_load;
  logic                   lfsr_adv;

  logic                   spike_bit;
  logic [SPIKE_WIDTH-1:0] packed_word;
  logic                   last_pixel;
  logic                   last_bit;
  logic                   last_step;

  assign lfsr_load  = (state == ST_IDLE) && start;
  assign lfsr_adv   = (state == ST_PACK);
  assign last_pixel = (pix_cnt == ADDR_WIDTH'(IMG_PIXELS - 1));
  assign last_bit   = (bit_cnt == BIT_W'(SPIKE_WIDTH - 1));
  assign last_step  = (step_cnt == STEP_W'(NUM_STEPS - 1));

  lfsr16 #(
    .RESET_VALUE (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (lfsr_load),
    .seed    (LFSR_SEED),
    .advance (lfsr_adv),
    .value   (lfsr_value)
  );

  // Spike decision for the registered pixel and the word with that bit merged in.
  always_comb begin
    spike_bit            = (pixel_reg > lfsr_value[DATA_WIDTH-1:0]);
    packed_word          = shift_word;
    packed_word[bit_cnt] = spike_bit;
  end

  // Encoder FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      pix_cnt     <= '0;
      bit_cnt     <= '0;
      step_cnt    <= '0;
      pixel_reg   <= '0;
      shift_word  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      spike_word  <= '0;
      spike_valid <= 1'b0;
      spike_step  <= '0;
      spike_last  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state      <= ST_READ;
            pix_cnt    <= '0;
            bit_cnt    <= '0;
            step_cnt   <= '0;
            shift_word <= '0;
            busy       <= 1'b1;
            rd_en      <= 1'b1;
            rd_addr    <= '0;
          end
        end
        ST_READ: begin
          rd_en <= 1'b0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          pixel_reg <= rd_data;
          state     <= ST_PACK;
        end
        ST_PACK: begin
          shift_word <= packed_word;
          if (last_bit || last_pixel) begin
            // Word is complete (full, or padded with zeros past the last pixel).
            state       <= ST_EMIT;
            spike_word  <= packed_word;
            spike_valid <= 1'b1;
            spike_step  <= step_cnt;
            spike_last  <= last_pixel && last_step;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            pix_cnt <= pix_cnt + 1'b1;
            rd_en   <= 1'b1;
            rd_addr <= pix_cnt + 1'b1;
            state   <= ST_READ;
          end
        end
        ST_EMIT: begin
          if (spike_ready) begin
            spike_valid <= 1'b0;
            spike_word  <= '0;
            spike_step  <= '0;
            spike_last  <= 1'b0;
            shift_word  <= '0;
            bit_cnt     <= '0;
            if (last_pixel && last_step) begin
              state <= ST_DONE;
              done  <= 1'b1;
              busy  <= 1'b0;
            end else if (last_pixel) begin
              pix_cnt  <= '0;
              step_cnt <= step_cnt + 1'b1;
              rd_en    <= 1'b1;
              rd_addr  <= '0;
              state    <= ST_READ;
            end else begin
              pix_cnt <= pix_cnt + 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= pix_cnt + 1'b1;
              state   <= ST_READ;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          done        <= 1'b0;
          rd_en       <= 1'b0;
          spike_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gauss_spike_encoder.sv
// Bench for gauss_spike_encoder, built with a reduced 80-pixel frame
// (3 words per step, last word half padded) so several frames stay short.
module tb_gauss_spike_encoder;

  localparam int IMG   = 80;
  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int NS    = 16;
  localparam int SW    = 32;
  localparam int SPW   = 4;
  localparam int WPS   = (IMG + SW - 1) / SW;
  localparam int TOTAL = NS * WPS;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [SW-1:0] spike_word;
  logic          spike_valid;
  logic          spike_ready;
  logic [SPW-1:0] spike_step;
  logic          spike_last;

  always #5 clk = ~clk;

  gauss_spike_encoder #(
    .IMG_PIXELS  (IMG),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .NUM_STEPS   (NS),
    .SPIKE_WIDTH (SW),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .rd_en       (rd_en),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .spike_word  (spike_word),
    .spike_valid (spike_valid),
    .spike_ready (spike_ready),
    .spike_step  (spike_step),
    .spike_last  (spike_last)
  );

  // Buffer model: one-cycle read latency.
  logic [7:0] mem [IMG];
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[int'(rd_addr)];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference LFSR: shift left, feedback from taps 16,14,13,11.
  function automatic logic [15:0] model_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  logic [31:0]    exp_word [TOTAL];
  logic [SPW-1:0] exp_step [TOTAL];
  logic           exp_last [TOTAL];

  task automatic build_expected();
    logic [15:0] l;
    logic [31:0] w;
    int p;
    l = 16'hACE1;
    for (int s = 0; s < NS; s++) begin
      for (int k = 0; k < WPS; k++) begin
        w = 32'h0;
        for (int b = 0; b < SW; b++) begin
          p = k * SW + b;
          if (p < IMG) begin
            if (mem[p] > l[7:0]) w[b] = 1'b1;
            l = model_step(l);
          end
        end
        exp_word[s*WPS+k] = w;
        exp_step[s*WPS+k] = SPW'(s);
        exp_last[s*WPS+k] = (s == NS - 1) && (k == WPS - 1);
      end
    end
  endtask

  task automatic fill(input int kind);
    for (int p = 0; p < IMG; p++)
      mem[p] = (kind == 0) ? 8'd0 : (kind == 1) ? 8'd255 : 8'(p % 256);
  endtask

  int             idx;
  int             done_cnt;
  int             spk_cnt [IMG];
  bit             chk_en = 1'b0;
  bit             rand_ready = 1'b0;
  bit             pend;
  bit             prev_stall;
  logic [31:0]    prev_word;
  logic [SPW-1:0] prev_step;
  logic           prev_last;

  // Consumer ready: always high or ~30% duty.
  initial begin
    spike_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      spike_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst || !chk_en) begin
      prev_stall = 1'b0;
      pend       = 1'b0;
    end else begin
      if (pend) begin
        chk("done_after_last", done, 1'b1);
        chk("busy_low_at_done", busy, 1'b0);
        pend = 1'b0;
      end
      if (done) done_cnt++;
      if (prev_stall) begin
        chk("stall_valid", spike_valid, 1'b1);
        chk("stall_word", spike_word, prev_word);
        chk("stall_step", spike_step, prev_step);
        chk("stall_last", spike_last, prev_last);
      end
      if (spike_valid) chk("busy_with_valid", busy, 1'b1);
      if (spike_valid && !spike_ready) chk("rd_en_while_stalled", rd_en, 1'b0);
      if (spike_valid && spike_ready) begin
        if (idx < TOTAL) begin
          chk($sformatf("word[%0d]", idx), spike_word, exp_word[idx]);
          chk($sformatf("step[%0d]", idx), spike_step, exp_step[idx]);
          chk($sformatf("last[%0d]", idx), spike_last, exp_last[idx]);
          for (int b = 0; b < SW; b++) begin
            if ((idx % WPS) * SW + b < IMG && spike_word[b])
              spk_cnt[(idx % WPS) * SW + b]++;
          end
        end else begin
          total++;
          bad++;
          $display("FAIL extra_word: got word %0d want at most %0d", idx + 1, TOTAL);
        end
        idx++;
        if (idx == TOTAL) pend = 1'b1;
      end
      prev_stall = spike_valid && !spike_ready;
      prev_word  = spike_word;
      prev_step  = spike_step;
      prev_last  = spike_last;
    end
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_en"}, rd_en, 1'b0);
    chk({tag, "_rd_addr"}, rd_addr, 7'd0);
    chk({tag, "_word"}, spike_word, 32'h0);
    chk({tag, "_valid"}, spike_valid, 1'b0);
    chk({tag, "_step"}, spike_step, 4'd0);
    chk({tag, "_last"}, spike_last, 1'b0);
  endtask

  task automatic begin_frame(input int kind, input bit rr);
    fill(kind);
    build_expected();
    idx      = 0;
    done_cnt = 0;
    for (int p = 0; p < IMG; p++) spk_cnt[p] = 0;
    rand_ready = rr;
    chk_en     = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run_frame(input int kind, input bit rr, input bit mid_start);
    begin_frame(kind, rr);
    for (int c = 0; c < 8000 && done_cnt == 0; c++) begin
      @(posedge clk);
      #1;
      start = mid_start && (c == 400);
    end
    start = 1'b0;
    chk("frame_timeout", done_cnt != 0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("word_count", idx, TOTAL);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_frame", busy, 1'b0);
    rand_ready = 1'b0;
  endtask

  initial begin
    int sum_lo;
    int sum_hi;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_outputs_zero("idle");

    // Hand-computed pins on the reference LFSR.
    chk("lfsr_step1", model_step(16'hACE1), 16'h59C3);
    chk("lfsr_step2", model_step(16'h59C3), 16'hB387);

    // All-zero frame: every word zero.
    fill(0);
    build_expected();
    chk("zero_model_first", exp_word[0], 32'h0);
    chk("zero_model_lastflag", exp_last[TOTAL-1], 1'b1);
    run_frame(0, 1'b0, 1'b0);

    // All-255 frame: low bytes E1, C3, 87 give three set bits; padding zero.
    fill(1);
    build_expected();
    chk("ones_model_bits", exp_word[0][2:0], 3'b111);
    chk("ones_model_pad", exp_word[WPS-1][31:16], 16'h0);
    chk("ones_model_notlast", exp_last[TOTAL-2], 1'b0);
    run_frame(1, 1'b0, 1'b0);

    // Ramp: pixels 0 and 1 stay below E1 and C3.
    fill(2);
    build_expected();
    chk("ramp_model_low", exp_word[0][1:0], 2'b00);
    run_frame(2, 1'b0, 1'b0);

    // Ramp with a stalling consumer, then spike-rate sanity.
    run_frame(2, 1'b1, 1'b0);
    sum_lo = 0;
    sum_hi = 0;
    for (int p = 0; p < IMG / 2; p++) sum_lo += spk_cnt[p];
    for (int p = IMG / 2; p < IMG; p++) sum_hi += spk_cnt[p];
    chk("ramp_pixel0_silent", spk_cnt[0], 0);
    chk("ramp_rate_monotone", sum_hi > sum_lo, 1'b1);

    // Extra start mid-frame is ignored; then a fresh start repeats the sequence.
    run_frame(2, 1'b0, 1'b1);
    run_frame(2, 1'b0, 1'b0);

    // Reset while step 7 is in progress (second word of that step).
    begin_frame(2, 1'b0);
    for (int c = 0; c < 8000 && idx < 7 * WPS + 1; c++) @(posedge clk);
    chk("reach_step7", idx >= 7 * WPS + 1, 1'b1);
    repeat (20) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    chk_outputs_zero("midreset");
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk("rd_en_after_reset", rd_en, 1'b0);
    end
    chk("no_done_after_reset", done_cnt, 0);
    run_frame(2, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
